cfg_write_sequencer: RTL and testbench



---
 rtl/cfg_seq_pkg.sv | 29 ++
 rtl/cfg_word_packer.sv | 65 ++++++
 rtl/cfg_write_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_cfg_write_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_seq_pkg.sv
// Shared definitions for the configuration write sequencer.
//
// Contents:
//   seq_state_e    - sequencer FSM state encoding
//   BYTES_PER_WORD - bytes packed into one configuration word
//   WORD_W         - configuration word width
//   byte_lane()    - MSB-first lane index of byte k within a word
package cfg_seq_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_SETTLE,
        ST_URST,
        ST_DONE
    } seq_state_e;

    // Byte 0 of a word lands in the top lane (bits 31:24), byte 3 in the bottom lane.
    function automatic logic [1:0] byte_lane(input logic [1:0] idx);
        return 2'd3 - idx;
    endfunction

endpackage

// File: rtl/cfg_word_packer.sv
// Byte-to-word packer for the configuration write sequencer.
//
// Collects four bytes over a valid/ready handshake into one 32-bit word,
// MSB-first. The word register is only written on an accepted byte, so it
// holds its value whenever the packer is not enabled.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_enable       sequencer is in its fill phase
//   i_clear        drop word_valid and restart the byte count
//   i_byte/i_valid byte stream input
//   o_ready        byte accepted this cycle when i_valid is also high
//   o_word         packed word (drives the fabric data port directly)
//   o_word_valid   a complete word is held; stays high until i_clear
//   o_word_taken   the fourth byte of a word is being accepted this cycle
module cfg_word_packer
    import cfg_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_clear,
    input  logic [7:0]        i_byte,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid,
    output logic              o_word_taken
);

    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_byte_cnt;
    logic              r_word_valid;
    logic              w_accept;

    assign o_ready      = i_enable && !r_word_valid;
    assign w_accept     = o_ready && i_valid;
    assign o_word_taken = w_accept && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_word_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word[{byte_lane(r_byte_cnt), 3'b000} +: 8] <= i_byte;
            end
            if (i_clear) begin
                r_byte_cnt   <= '0;
                r_word_valid <= 1'b0;
            end else if (w_accept) begin
                if (o_word_taken) begin
                    r_byte_cnt   <= '0;
                    r_word_valid <= 1'b1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cfg_write_sequencer.sv
// Configuration write sequencer: loads a byte stream into the fabric through
// its SelfWriteData/SelfWriteStrobe port, then settles and pulses user_reset.
//
// Build option: CFG_CHECKSUM_EN adds expected_sum and aborts the load with
// error (no user_reset, no done) when the wrapping sum of strobed words differs.
//
// Ports:
//   CLK, resetn        clock, asynchronous active-low reset
//   start, num_words   load request and word count (sampled in IDLE/DONE)
//   byte_data/valid    bitstream byte input, byte_ready handshake output
//   SelfWriteData      configuration word, changes only while filling
//   SelfWriteStrobe    one-cycle write strobe per word
//   user_reset         user design reset pulse after settling
//   busy, done, error  status (done held, error sticky until a good start)
//   expected_sum       (CFG_CHECKSUM_EN only) reference sum, sampled on start
//
// state  | meaning
// IDLE   | waiting for start after reset or a checksum abort
// FILL   | accepting the four bytes of the next word
// SETUP  | data stable ahead of the strobe
// STROBE | SelfWriteStrobe high for one cycle
// HOLD   | data held after the strobe, word counter advances on exit
// SETTLE | idle delay after the last word
// URST   | user_reset asserted
// DONE   | load complete, waiting for the next start
module cfg_write_sequencer
    import cfg_seq_pkg::*;
#(
    parameter int SETUP_CYCLES    = 2,
    parameter int HOLD_CYCLES     = 2,
    parameter int MAX_WORDS       = 4096,
    parameter int SETTLE_CYCLES   = 100,
    parameter int USER_RST_CYCLES = 5,
    parameter int CNT_W           = 13
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
`ifdef CFG_CHECKSUM_EN
    input  logic [WORD_W-1:0] expected_sum,
`endif
    output logic              byte_ready,
    output logic [WORD_W-1:0] SelfWriteData,
    output logic              SelfWriteStrobe,
    output logic              user_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] URST_LD   = TMR_W'(USER_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_WORDS_C = CNT_W'(MAX_WORDS);

    seq_state_e       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_num_words;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_strobe;
    logic             r_user_rst;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic             w_num_ok;
    logic             w_start_ok;
    logic             w_timer_tc;
    logic [CNT_W-1:0] w_word_cnt_nxt;
    logic             w_last_word;
    logic             w_sum_ok;
    logic             w_fill;
    logic             w_clear;
    logic             w_word_valid;
    logic             w_word_taken;

    assign w_num_ok       = (num_words != '0) && (num_words <= MAX_WORDS_C);
    assign w_start_ok     = start && w_num_ok && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_timer_tc     = (r_timer == '0);
    assign w_word_cnt_nxt = r_word_cnt + 1'b1;
    assign w_last_word    = (w_word_cnt_nxt == r_num_words);
    assign w_fill         = (r_state == ST_FILL);
    // Release the packed word when the hold window closes, or restart on a new load.
    assign w_clear        = w_start_ok || ((r_state == ST_HOLD) && w_timer_tc && w_word_valid);

    cfg_word_packer u_packer (
        .clk          (CLK),
        .rst_n        (resetn),
        .i_enable     (w_fill),
        .i_clear      (w_clear),
        .i_byte       (byte_data),
        .i_valid      (byte_valid),
        .o_ready      (byte_ready),
        .o_word       (SelfWriteData),
        .o_word_valid (w_word_valid),
        .o_word_taken (w_word_taken)
    );

`ifdef CFG_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;
    logic [WORD_W-1:0] r_exp_sum;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_sum     <= '0;
            r_exp_sum <= '0;
        end else if (w_start_ok) begin
            r_sum     <= '0;
            r_exp_sum <= expected_sum;
        end else if (r_state == ST_STROBE) begin
            r_sum <= r_sum + SelfWriteData;
        end
    end

    assign w_sum_ok = (r_sum == r_exp_sum);
`else
    assign w_sum_ok = 1'b1;
`endif

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_num_words <= '0;
            r_word_cnt  <= '0;
            r_strobe    <= 1'b0;
            r_user_rst  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (w_num_ok) begin
                            r_done      <= 1'b0;
                            r_error     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_num_words <= num_words;
                            r_word_cnt  <= '0;
                            r_state     <= ST_FILL;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_word_taken) begin
                        r_timer <= SETUP_LD;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_timer_tc) begin
                        r_strobe <= 1'b1;
                        r_state  <= ST_STROBE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_STROBE: begin
                    r_strobe <= 1'b0;
                    r_timer  <= HOLD_LD;
                    r_state  <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_timer_tc) begin
                        r_word_cnt <= w_word_cnt_nxt;
                        if (w_last_word && w_sum_ok) begin
                            r_timer <= SETTLE_LD;
                            r_state <= ST_SETTLE;
                        end else if (w_last_word) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_timer_tc) begin
                        r_user_rst <= 1'b1;
                        r_timer    <= URST_LD;
                        r_state    <= ST_URST;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_URST: begin
                    if (w_timer_tc) begin
                        r_user_rst <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign SelfWriteStrobe = r_strobe;
    assign user_reset      = r_user_rst;
    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;

endmodule

// File: tb/tb_cfg_write_sequencer.sv
module tb_cfg_write_sequencer;

    localparam int CNT_W      = 13;
    localparam int WORD_GAP   = 9;            // 4 fill + 2 setup + 1 strobe + 2 hold
    localparam int URST_DELAY = 1 + 2 + 100;  // strobe cycle, hold, settle
    localparam int URST_LEN   = 5;

    logic             CLK = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic [7:0]       byte_data = '0;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic [31:0]      SelfWriteData;
    logic             SelfWriteStrobe;
    logic             user_reset;
    logic             busy;
    logic             done;
    logic             error;
`ifdef CFG_CHECKSUM_EN
    logic [31:0]      expected_sum = '0;
`endif

    cfg_write_sequencer dut (
        .CLK             (CLK),
        .resetn          (resetn),
        .start           (start),
        .num_words       (num_words),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
`ifdef CFG_CHECKSUM_EN
        .expected_sum    (expected_sum),
`endif
        .byte_ready      (byte_ready),
        .SelfWriteData   (SelfWriteData),
        .SelfWriteStrobe (SelfWriteStrobe),
        .user_reset      (user_reset),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          strobe_cyc[$];
    int          urst_rise = -1;
    int          urst_len = 0;
    int          urst_total = 0;
    logic        urst_d = 1'b0;
    logic [31:0] last_sum = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every strobe pops the next expected word.
    always @(negedge CLK) begin
        if (SelfWriteStrobe === 1'b1) begin
            strobe_cyc.push_back(cyc);
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_strobe: observed strobe with data %h expected none", SelfWriteData);
            end
            if (exp_q.size() != 0) check("strobe_word", SelfWriteData, exp_q.pop_front());
        end
        if (user_reset === 1'b1 && urst_d !== 1'b1) begin
            urst_rise = cyc;
            urst_len  = 0;
        end
        if (user_reset === 1'b1) begin
            urst_len++;
            urst_total++;
        end
        urst_d = user_reset;
        cyc++;
    end

    task automatic pulse_start(input int n, input logic [31:0] sum);
        start     = 1'b1;
        num_words = CNT_W'(n);
        last_sum  = sum;
`ifdef CFG_CHECKSUM_EN
        expected_sum = sum;
`endif
        @(negedge CLK);
        start = 1'b0;
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_after, input int gap_len,
                             input logic [31:0] prev);
        int n;
        int s_before;
        exp_q.push_back(w);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            byte_data  = w[31-8*k -: 8];
            byte_valid = 1'b1;
            while (byte_ready !== 1'b1 && n < 500) begin
                @(negedge CLK);
                n++;
            end
            tests++;
            assert (n < 500) else begin
                fails++;
                $error("FAIL byte_accept_timeout: observed no byte_ready in %0d cycles expected ready", n);
            end
            @(negedge CLK);
            byte_valid = 1'b0;
            if (k == gap_after) begin
                s_before = strobe_cyc.size();
                repeat (gap_len) @(negedge CLK);
                #1;
                check("gap_no_strobe", 32'(strobe_cyc.size()), 32'(s_before));
                check("gap_ready_held", {31'd0, byte_ready}, 32'd1);
                check("gap_partial_word", SelfWriteData, {w[31:16], prev[15:0]});
            end
        end
    endtask

    task automatic wait_not_busy(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        #1;
        tests++;
        assert (n < 3000) else begin
            fails++;
            $error("FAIL %s_timeout: observed busy after %0d cycles expected idle", tag, n);
        end
    endtask

    task automatic check_run(input string tag, input int s0, input int nexp, input logic [31:0] last_word);
        int n;
        n = strobe_cyc.size() - s0;
        check({tag, "_strobes"}, 32'(n), 32'(nexp));
        for (int i = 1; i < n; i++)
            check({tag, "_spacing"}, 32'(strobe_cyc[s0+i] - strobe_cyc[s0+i-1]), 32'(WORD_GAP));
        if (n > 0) check({tag, "_urst_delay"}, 32'(urst_rise - strobe_cyc[s0+n-1]), 32'(URST_DELAY));
        check({tag, "_urst_len"}, 32'(urst_len), 32'(URST_LEN));
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_data_kept"}, SelfWriteData, last_word);
    endtask

    initial begin
        int s0;
        int n;
        int bad_ready;
        int urst_snap;

        // Reset values
        repeat (3) @(negedge CLK);
        #1;
        check("rst_data", SelfWriteData, 32'h0);
        check("rst_strobe", {31'd0, SelfWriteStrobe}, 32'd0);
        check("rst_urst", {31'd0, user_reset}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        resetn = 1'b1;
        @(negedge CLK);

        // 1: two words, no gaps
        s0 = strobe_cyc.size();
        pulse_start(2, 32'h01020304 + 32'h05060708);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_word(32'h01020304, -1, 0, 32'h0);
        send_word(32'h05060708, -1, 0, 32'h0);
        wait_not_busy("t1");
        check_run("t1", s0, 2, 32'h05060708);

        // 2: source stalls for 20 cycles after byte 2 of the first word
        @(negedge CLK);
        s0 = strobe_cyc.size();
        pulse_start(2, 32'hA1A2A3A4 + 32'hB1B2B3B4);
        send_word(32'hA1A2A3A4, 1, 20, 32'h05060708);
        send_word(32'hB1B2B3B4, -1, 0, 32'h0);
        wait_not_busy("t2");
        check("t2_strobes", 32'(strobe_cyc.size() - s0), 32'd2);
        check("t2_done", {31'd0, done}, 32'd1);

        // 3: bad word counts, then a good start clears error
        @(negedge CLK);
        pulse_start(0, 32'h0);
        check("t3_zero_error", {31'd0, error}, 32'd1);
        check("t3_zero_busy", {31'd0, busy}, 32'd0);
        check("t3_zero_done_held", {31'd0, done}, 32'd1);
        pulse_start(4097, 32'h0);
        check("t3_big_error", {31'd0, error}, 32'd1);
        check("t3_big_busy", {31'd0, busy}, 32'd0);
        s0 = strobe_cyc.size();
        pulse_start(1, 32'hCAFEF00D);
        check("t3_good_error_clr", {31'd0, error}, 32'd0);
        check("t3_good_done_clr", {31'd0, done}, 32'd0);
        check("t3_good_busy", {31'd0, busy}, 32'd1);
        send_word(32'hCAFEF00D, -1, 0, 32'h0);
        wait_not_busy("t3");
        check_run("t3", s0, 1, 32'hCAFEF00D);

        // 4: reset asserted during HOLD of word 3 of 5
        @(negedge CLK);
        s0 = strobe_cyc.size();
        pulse_start(5, 32'h0);
        send_word(32'h10203040, -1, 0, 32'h0);
        send_word(32'h50607080, -1, 0, 32'h0);
        send_word(32'h90A0B0C0, -1, 0, 32'h0);
        n = 0;
        while (SelfWriteStrobe !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("t4_third_strobe_seen", {31'd0, SelfWriteStrobe}, 32'd1);
        @(posedge CLK);
        #2;
        resetn = 1'b0;
        #1;
        check("t4_async_data", SelfWriteData, 32'h0);
        check("t4_async_strobe", {31'd0, SelfWriteStrobe}, 32'd0);
        check("t4_async_urst", {31'd0, user_reset}, 32'd0);
        check("t4_async_busy", {31'd0, busy}, 32'd0);
        check("t4_async_done", {31'd0, done}, 32'd0);
        check("t4_async_error", {31'd0, error}, 32'd0);
        check("t4_async_ready", {31'd0, byte_ready}, 32'd0);
        @(negedge CLK);
        resetn     = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        bad_ready  = 0;
        repeat (40) begin
            @(negedge CLK);
            if (byte_ready !== 1'b0) bad_ready++;
        end
        byte_valid = 1'b0;
        #1;
        check("t4_strobes_before_reset", 32'(strobe_cyc.size() - s0), 32'd3);
        check("t4_no_ready_in_idle", 32'(bad_ready), 32'd0);
        check("t4_idle_busy", {31'd0, busy}, 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: start pulses while busy are ignored
        s0 = strobe_cyc.size();
        pulse_start(2, 32'h11223344 + 32'h55667788);
        send_word(32'h11223344, -1, 0, 32'h0);
        pulse_start(1, 32'h0);
        send_word(32'h55667788, -1, 0, 32'h0);
        repeat (20) @(negedge CLK);
        pulse_start(3, 32'h0);
        wait_not_busy("t5");
        check_run("t5", s0, 2, 32'h55667788);

`ifdef CFG_CHECKSUM_EN
        // 6: checksum match and mismatch
        @(negedge CLK);
        s0 = strobe_cyc.size();
        pulse_start(2, 32'h00000001);
        send_word(32'hFFFFFFFF, -1, 0, 32'h0);
        send_word(32'h00000002, -1, 0, 32'h0);
        wait_not_busy("t6a");
        check_run("t6a", s0, 2, 32'h00000002);
        urst_snap = urst_total;
        @(negedge CLK);
        pulse_start(2, 32'h00000000);
        send_word(32'hFFFFFFFF, -1, 0, 32'h0);
        send_word(32'h00000002, -1, 0, 32'h0);
        wait_not_busy("t6b");
        repeat (120) @(negedge CLK);
        #1;
        check("t6b_error", {31'd0, error}, 32'd1);
        check("t6b_done", {31'd0, done}, 32'd0);
        check("t6b_busy", {31'd0, busy}, 32'd0);
        check("t6b_no_urst", 32'(urst_total), 32'(urst_snap));
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
